vgm_wb_master: RTL and testbench

Wishbone classic single-transfer bus master. It converts a simple valid/ready command/response interface into Wishbone B4 classic cycles. It drives the CYC_O/STB_O/ADR_O/ACK_I signal group that vgm_wb_master_sva_checker monitors. One outstanding transfer at a time; ERR_I and a cycle timeout are both supported.

---
 rtl/vgm_wb_pkg.sv | 20 ++
 rtl/vgm_wb_timeout_counter.sv | 43 ++++
 rtl/vgm_wb_master.sv | 152 +++++++++++++++
 tb/tb_vgm_wb_master.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vgm_wb_pkg.sv
// Shared types for the Wishbone classic master: FSM states, default bus widths, response record.
// The response record's rdata width bounds the largest supported DATA_W.
package vgm_wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_master_state_e;

  typedef struct packed {
    logic [WB_DATA_W-1:0] rdata;
    logic                 err;
    logic                 timeout;
  } wb_rsp_t;

endpackage

// File: rtl/vgm_wb_timeout_counter.sv
// Bus-cycle watchdog: expired_o is high combinationally once TIMEOUT-1 enabled cycles have elapsed.
// No latency beyond the count register; TIMEOUT=0 removes the counter and never expires.
module vgm_wb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_i, clear_i, enable_i};
    assign expired_o     = 1'b0;
  end else begin : g_on
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Saturate at the terminal value so a late disable cannot wrap the count.
    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (enable_i && !expired_o) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/vgm_wb_master.sv
// Wishbone B4 classic single-transfer master; accept-to-STB_O latency 1 cycle, ERR_I > ACK_I > timeout.
// One transfer outstanding: req_ready only in IDLE, response held in RESP until rsp_ready. DATA_W <= WB_DATA_W.
module vgm_wb_master
  import vgm_wb_pkg::*;
#(
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                CYC_O,
  output logic                STB_O,
  output logic                WE_O,
  output logic [ADDR_W-1:0]   ADR_O,
  output logic [DATA_W-1:0]   DAT_O,
  output logic [DATA_W/8-1:0] SEL_O,
  input  logic [DATA_W-1:0]   DAT_I,
  input  logic                ACK_I,
  input  logic                ERR_I
);

  localparam int SEL_W = DATA_W / 8;

  wb_master_state_e state_q, state_d;

  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              rsp_vld_q, rsp_vld_d;
  wb_rsp_t           rsp_q, rsp_d;

  logic accept;
  logic cnt_clear;
  logic cnt_en;
  logic expired;

  assign req_ready = (state_q == IDLE) && !RST_I;
  assign accept    = req_valid && req_ready;
  assign cnt_en    = (state_q == BUS);

  vgm_wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (CLK_I),
    .rst_i     (RST_I),
    .clear_i   (cnt_clear),
    .enable_i  (cnt_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_vld_d = rsp_vld_q;
    rsp_d     = rsp_q;
    cnt_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          adr_d     = req_addr;
          we_d      = req_we;
          dat_d     = req_wdata;
          sel_d     = req_sel;
          cyc_d     = 1'b1;
          cnt_clear = 1'b1;
          state_d   = BUS;
        end
      end

      BUS: begin
        // Address/data/select registers are deliberately left holding the last transfer.
        if (ERR_I || ACK_I || expired) begin
          cyc_d     = 1'b0;
          rsp_vld_d = 1'b1;
          state_d   = RESP;
          if (ERR_I) begin
            rsp_d = '{rdata: '0, err: 1'b1, timeout: 1'b0};
          end else if (ACK_I) begin
            rsp_d = '{rdata: (we_q ? '0 : WB_DATA_W'(DAT_I)), err: 1'b0, timeout: 1'b0};
          end else begin
            rsp_d = '{rdata: '0, err: 1'b1, timeout: 1'b1};
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_q     <= rsp_d;
    end
  end

  // Single-transfer classic cycles: strobe and cycle are the same register.
  assign CYC_O       = cyc_q;
  assign STB_O       = cyc_q;
  assign WE_O        = we_q;
  assign ADR_O       = adr_q;
  assign DAT_O       = dat_q;
  assign SEL_O       = sel_q;
  assign rsp_valid   = rsp_vld_q;
  assign rsp_rdata   = DATA_W'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_vgm_wb_master.sv
// Testbench for vgm_wb_master: directed scenarios plus randomized transfers against a transfer-level model.
module tb_vgm_wb_master;

  localparam int TO     = 16;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic        clk = 1'b0;
  logic        RST_I;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        CYC_O, STB_O, WE_O;
  logic [31:0] ADR_O, DAT_O, DAT_I;
  logic [3:0]  SEL_O;
  logic        ACK_I, ERR_I;

  logic        d0_req_valid, d0_req_ready, d0_rsp_valid, d0_rsp_err, d0_rsp_timeout;
  logic [31:0] d0_rsp_rdata, d0_adr, d0_dat;
  logic [3:0]  d0_sel;
  logic        d0_cyc, d0_stb, d0_we, d0_ack;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vgm_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .CLK_I(clk), .RST_I(RST_I),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
  );

  vgm_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut0 (
    .CLK_I(clk), .RST_I(RST_I),
    .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_addr(32'h40), .req_we(1'b0),
    .req_wdata(32'h0), .req_sel(4'hF),
    .rsp_valid(d0_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(d0_rsp_rdata), .rsp_err(d0_rsp_err),
    .rsp_timeout(d0_rsp_timeout),
    .CYC_O(d0_cyc), .STB_O(d0_stb), .WE_O(d0_we), .ADR_O(d0_adr), .DAT_O(d0_dat), .SEL_O(d0_sel),
    .DAT_I(32'h1234_5678), .ACK_I(d0_ack), .ERR_I(1'b0)
  );

  // Transfer-level expectation: how long the strobe lasts and what the response carries.
  function automatic void model(input int kind, input logic we, input logic [31:0] rdat, input int wt,
                                output int stb, output logic [31:0] rd, output logic er, output logic to);
    if (kind == K_NONE || wt + 1 > TO) begin
      stb = TO; rd = 32'h0; er = 1'b1; to = 1'b1;
    end else begin
      stb = wt + 1; to = 1'b0;
      er  = (kind != K_ACK);
      rd  = (er || we) ? 32'h0 : rdat;
    end
  endfunction

  task automatic run_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [3:0] sel, input int kind, input int wt,
                          input logic [31:0] rdat, input int hold);
    int n, exp_stb, g;
    logic stable, bad, er, to;
    logic [31:0] rd;
    model(kind, we, rdat, wt, exp_stb, rd, er, to);
    req_addr = addr; req_we = we; req_wdata = wdata; req_sel = sel;
    req_valid = 1'b1; rsp_ready = (hold == 0);
    g = 0;
    while (req_ready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_we = 1'($urandom); req_wdata = $urandom; req_sel = 4'($urandom);
    n_vec++;
    if ({CYC_O, STB_O, req_ready} !== 3'b110) begin
      n_err++; $display("FAIL accept_latency: cyc/stb/rdy=%b want 110", {CYC_O, STB_O, req_ready});
    end
    n = 0; stable = 1'b1;
    while (STB_O === 1'b1 && n < 100) begin
      n++;
      if (CYC_O !== STB_O || ADR_O !== addr || WE_O !== we || DAT_O !== wdata || SEL_O !== sel)
        stable = 1'b0;
      ACK_I = (kind == K_ACK || kind == K_BOTH) && (n == wt + 1);
      ERR_I = (kind == K_ERR || kind == K_BOTH) && (n == wt + 1);
      DAT_I = (n == wt + 1) ? rdat : $urandom;
      @(posedge clk); #1;
    end
    ACK_I = 1'b0; ERR_I = 1'b0;
    n_vec++;
    if (n != exp_stb) begin n_err++; $display("FAIL stb_cycles: got %0d want %0d", n, exp_stb); end
    n_vec++;
    if (!stable) begin n_err++; $display("FAIL bus_stable: addr %h we %b dat %h sel %h changed", addr, we, wdata, sel); end
    n_vec++;
    if ({rsp_valid, CYC_O, ADR_O} !== {1'b1, 1'b0, addr}) begin
      n_err++; $display("FAIL term_state: vld/cyc=%b%b adr=%h want 10 %h", rsp_valid, CYC_O, ADR_O, addr);
    end
    n_vec++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== {rd, er, to}) begin
      n_err++; $display("FAIL rsp_fields: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, rd, er, to);
    end
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      ACK_I = 1'($urandom); ERR_I = 1'($urandom); DAT_I = $urandom;
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || {rsp_rdata, rsp_err, rsp_timeout} !== {rd, er, to} ||
          req_ready !== 1'b0 || CYC_O !== 1'b0) bad = 1'b1;
    end
    ACK_I = 1'b0; ERR_I = 1'b0;
    if (hold > 0) begin
      n_vec++;
      if (bad) begin n_err++; $display("FAIL resp_hold: response not stable over %0d stalled cycles", hold); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_err++; $display("FAIL resp_release: vld/rdy=%b want 01", {rsp_valid, req_ready});
    end
  endtask

  task automatic test_reset();
    RST_I = 1'b1; req_valid = 1'b1; req_addr = $urandom; req_we = 1'b1; req_wdata = $urandom;
    req_sel = 4'hF; rsp_ready = 1'b0; ACK_I = 1'b1; ERR_I = 1'b0; DAT_I = $urandom; d0_req_valid = 1'b0;
    d0_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
      n_err++; $display("FAIL reset_outputs: cyc %b stb %b we %b adr %h dat %h sel %h vld %b rd %h err %b to %b want all 0",
                        CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
    end
    req_valid = 1'b0; ACK_I = 1'b0; RST_I = 1'b0;
    #1;
    n_vec++;
    if ({req_ready, d0_req_ready} !== 2'b11) begin
      n_err++; $display("FAIL reset_ready: got %b want 11", {req_ready, d0_req_ready});
    end
  endtask

  task automatic test_directed();
    run_xfer(32'h1000, 1'b0, 32'h0, 4'hF, K_ACK, 2, 32'hDEADBEEF, 0);
    run_xfer(32'h20, 1'b1, 32'h55AA, 4'b0011, K_ACK, 0, 32'hFFFF_FFFF, 0);
    run_xfer(32'h300, 1'b0, 32'h0, 4'hF, K_BOTH, 1, 32'hCAFE_F00D, 0);
    run_xfer(32'h400, 1'b0, 32'h0, 4'hF, K_NONE, 0, 32'h0, 0);
    run_xfer(32'h500, 1'b0, 32'h0, 4'hF, K_ACK, 0, 32'hA5A5_0001, 5);
  endtask

  task automatic test_back_to_back();
    int nstart, last;
    logic prev, gap_bad, fld_bad;
    rsp_ready = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55AA; req_sel = 4'b0011;
    req_valid = 1'b1;
    prev = 1'b0; nstart = 0; last = -1; gap_bad = 1'b0; fld_bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      ACK_I = STB_O; DAT_I = $urandom;
      if (STB_O && !prev) begin
        if (last >= 0 && c - last != 3) gap_bad = 1'b1;
        last = c; nstart++;
        if (WE_O !== 1'b1 || DAT_O !== 32'h55AA || SEL_O !== 4'b0011 || ADR_O !== 32'h20) fld_bad = 1'b1;
      end
      if (rsp_valid && (rsp_rdata !== 32'h0 || rsp_err !== 1'b0)) fld_bad = 1'b1;
      prev = STB_O;
    end
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; ACK_I = STB_O; end
    ACK_I = 1'b0;
    n_vec++;
    if (nstart != 7) begin n_err++; $display("FAIL b2b_count: got %0d starts want 7", nstart); end
    n_vec++;
    if (gap_bad) begin n_err++; $display("FAIL b2b_gap: start spacing not 3 cycles (last start %0d)", last); end
    n_vec++;
    if (fld_bad) begin n_err++; $display("FAIL b2b_fields: write fields or rsp_rdata wrong"); end
    n_vec++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_drain: req_ready=%b want 1", req_ready); end
  endtask

  task automatic test_reset_mid_bus();
    logic seen;
    req_addr = 32'h600; req_we = 1'b0; req_wdata = 32'h0; req_sel = 4'hF; rsp_ready = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (STB_O !== 1'b1) begin n_err++; $display("FAIL mid_reset_pre: stb=%b want 1", STB_O); end
    RST_I = 1'b1;
    @(posedge clk); #1;
    RST_I = 1'b0;
    #1;
    n_vec++;
    if ({CYC_O, STB_O, req_ready, rsp_valid} !== 4'b0010) begin
      n_err++; $display("FAIL mid_reset: cyc/stb/rdy/vld=%b want 0010", {CYC_O, STB_O, req_ready, rsp_valid});
    end
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (rsp_valid !== 1'b0 || CYC_O !== 1'b0) seen = 1'b1; end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL mid_reset_quiet: response or cycle after reset"); end
    run_xfer(32'h700, 1'b0, 32'h0, 4'hF, K_ACK, 1, 32'h0BAD_F00D, 0);
  endtask

  task automatic test_timeout_disabled();
    logic drop;
    d0_req_valid = 1'b1;
    @(posedge clk); #1;
    d0_req_valid = 1'b0;
    drop = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (d0_cyc !== 1'b1 || d0_stb !== 1'b1 || d0_rsp_valid !== 1'b0) drop = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (drop) begin n_err++; $display("FAIL no_timeout: cycle dropped with TIMEOUT=0"); end
    d0_ack = 1'b1;
    @(posedge clk); #1;
    d0_ack = 1'b0;
    n_vec++;
    if ({d0_rsp_valid, d0_rsp_err, d0_rsp_timeout, d0_rsp_rdata} !== {3'b100, 32'h1234_5678}) begin
      n_err++; $display("FAIL no_timeout_rsp: vld/err/to=%b rd=%h want 100 12345678",
                        {d0_rsp_valid, d0_rsp_err, d0_rsp_timeout}, d0_rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int r, kind;
    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 9));
      kind = (r < 6) ? K_ACK : (r < 8) ? K_ERR : (r == 8) ? K_BOTH : K_NONE;
      run_xfer($urandom, 1'($urandom), $urandom, 4'($urandom), kind,
               int'($urandom_range(0, 4)), $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_bus();
    test_timeout_disabled();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
